// File: rtl/chacha_poly1305_feeder.sv
// Splits a tagged AAD/payload beat stream into Poly1305 accumulator blocks,
// zero-filling unused bytes and closing each message with the length block.
module chacha_poly1305_feeder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    input  logic [15:0]  in_keep,
    input  logic         in_is_aad,
    input  logic         in_last,
    output logic         in_ready,
    output logic         aad_valid,
    output logic [127:0] aad_data,
    output logic [15:0]  aad_keep,
    input  logic         aad_ready,
    output logic         pld_valid,
    output logic [127:0] pld_data,
    output logic [15:0]  pld_keep,
    input  logic         pld_ready,
    output logic         len_valid,
    output logic [127:0] len_block,
    input  logic         len_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AAD  = 3'd1;
    localparam logic [2:0] ST_PLD  = 3'd2;
    localparam logic [2:0] ST_LEN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic [127:0] zero_fill(input logic [127:0] d, input logic [15:0] k);
        logic [127:0] r;
        r = 128'd0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
        end
        return r;
    endfunction

    function automatic logic [63:0] keep_count(input logic [15:0] k);
        logic [63:0] c;
        c = 64'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {63'd0, k[i]};
        end
        return c;
    endfunction

    // A legal keep is 2^n-1: adding one must carry through every set bit.
    function automatic logic keep_contig(input logic [15:0] k);
        return ((k & (k + 16'd1)) == 16'd0);
    endfunction

    logic [2:0]   state_r, state_n;
    logic         in_ready_r;
    logic         aad_valid_r, aad_valid_n;
    logic         pld_valid_r, pld_valid_n;
    logic [127:0] data_r, data_n;
    logic [15:0]  keep_r, keep_n;
    logic [63:0]  aad_cnt_r, aad_cnt_n;
    logic [63:0]  pld_cnt_r, pld_cnt_n;
    logic         last_r, last_n;
    logic         aad_part_r, aad_part_n;
    logic         err_r, err_n;
    logic         len_valid_r, len_valid_n;
    logic [127:0] len_block_r, len_block_n;
    logic         done_r, done_n;
    logic         busy_r;

    logic         accept_s;
    logic         out_hs_s;
    logic         route_aad_s;
    logic         keep_partial_s;
    logic         beat_err_s;
    logic [63:0]  nbytes_s;

    // Handshake and per-beat classification.
    always_comb begin
        accept_s       = in_valid && in_ready_r;
        out_hs_s       = (aad_valid_r && aad_ready) || (pld_valid_r && pld_ready);
        route_aad_s    = in_is_aad && (state_r == ST_AAD);
        keep_partial_s = (in_keep != 16'hFFFF) && (in_keep != 16'h0000);
        nbytes_s       = keep_count(in_keep);
        beat_err_s     = !keep_contig(in_keep)
                       || (in_is_aad && aad_part_r)
                       || (in_is_aad && (state_r == ST_PLD))
                       || (!route_aad_s && keep_partial_s && !in_last);
    end

    // Next-state and datapath update for the whole message sequencer.
    always_comb begin
        state_n     = state_r;
        aad_valid_n = aad_valid_r;
        pld_valid_n = pld_valid_r;
        data_n      = data_r;
        keep_n      = keep_r;
        aad_cnt_n   = aad_cnt_r;
        pld_cnt_n   = pld_cnt_r;
        last_n      = last_r;
        aad_part_n  = aad_part_r;
        err_n       = err_r;
        len_valid_n = len_valid_r;
        len_block_n = len_block_r;
        done_n      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n    = ST_AAD;
                    aad_cnt_n  = 64'd0;
                    pld_cnt_n  = 64'd0;
                    err_n      = 1'b0;
                    last_n     = 1'b0;
                    aad_part_n = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_AAD, ST_PLD: begin
                if (out_hs_s) begin
                    aad_valid_n = 1'b0;
                    pld_valid_n = 1'b0;
                    if (last_r) begin
                        state_n     = ST_LEN;
                        len_valid_n = 1'b1;
                        len_block_n = {pld_cnt_r, aad_cnt_r};
                    end else begin
                        state_n = state_r;
                    end
                end else if (accept_s) begin
                    err_n = err_r || beat_err_s;
                    if (route_aad_s) begin
                        aad_cnt_n  = aad_cnt_r + nbytes_s;
                        aad_part_n = keep_partial_s;
                    end else begin
                        pld_cnt_n = pld_cnt_r + nbytes_s;
                        state_n   = ST_PLD;
                    end
                    // Empty beats only carry in_last; nothing is forwarded.
                    if (in_keep != 16'h0000) begin
                        aad_valid_n = route_aad_s;
                        pld_valid_n = !route_aad_s;
                        data_n      = zero_fill(in_data, in_keep);
                        keep_n      = in_keep;
                        last_n      = in_last;
                    end else if (in_last) begin
                        state_n     = ST_LEN;
                        len_valid_n = 1'b1;
                        len_block_n = {pld_cnt_r, aad_cnt_r};
                    end else begin
                        last_n = last_r;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            ST_LEN: begin
                if (len_ready) begin
                    len_valid_n = 1'b0;
                    state_n     = ST_DONE;
                    done_n      = 1'b1;
                end else begin
                    len_valid_n = 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n     = ST_IDLE;
                aad_valid_n = 1'b0;
                pld_valid_n = 1'b0;
                len_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers; in_ready and busy are precomputed from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            aad_valid_r <= 1'b0;
            pld_valid_r <= 1'b0;
            data_r      <= 128'd0;
            keep_r      <= 16'd0;
            aad_cnt_r   <= 64'd0;
            pld_cnt_r   <= 64'd0;
            last_r      <= 1'b0;
            aad_part_r  <= 1'b0;
            err_r       <= 1'b0;
            len_valid_r <= 1'b0;
            len_block_r <= 128'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            in_ready_r  <= ((state_n == ST_AAD) || (state_n == ST_PLD))
                           && !(aad_valid_n || pld_valid_n);
            aad_valid_r <= aad_valid_n;
            pld_valid_r <= pld_valid_n;
            data_r      <= data_n;
            keep_r      <= keep_n;
            aad_cnt_r   <= aad_cnt_n;
            pld_cnt_r   <= pld_cnt_n;
            last_r      <= last_n;
            aad_part_r  <= aad_part_n;
            err_r       <= err_n;
            len_valid_r <= len_valid_n;
            len_block_r <= len_block_n;
            done_r      <= done_n;
            busy_r      <= (state_n != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign aad_valid = aad_valid_r;
    assign aad_data  = data_r;
    assign aad_keep  = keep_r;
    assign pld_valid = pld_valid_r;
    assign pld_data  = data_r;
    assign pld_keep  = keep_r;
    assign len_valid = len_valid_r;
    assign len_block = len_block_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_chacha_poly1305_feeder.sv
// Bench for chacha_poly1305_feeder: table of message beats plus hand sequences,
// with a scoreboard queue checked at every downstream handshake.
module tb_chacha_poly1305_feeder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = 128'd0;
    logic [15:0]  in_keep = 16'd0;
    logic         in_is_aad = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         aad_valid, pld_valid, len_valid;
    logic [127:0] aad_data, pld_data, len_block;
    logic [15:0]  aad_keep, pld_keep;
    logic         aad_ready = 1'b1;
    logic         pld_ready = 1'b1;
    logic         len_ready = 1'b1;
    logic         busy, done, err;

    chacha_poly1305_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep),
        .in_is_aad(in_is_aad), .in_last(in_last), .in_ready(in_ready),
        .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready),
        .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready),
        .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_AAD = 2'd0;
    localparam logic [1:0] K_PLD = 2'd1;
    localparam logic [1:0] K_LEN = 2'd2;

    typedef struct {
        logic [1:0]   kind;
        logic [127:0] data;
        logic [15:0]  keep;
    } exp_t;

    typedef struct {
        logic         st;
        logic         is_aad;
        logic [15:0]  keep;
        logic [127:0] data;
        logic         last;
        logic [127:0] exp_data;
        logic         exp_err;
    } vec_t;

    exp_t  sb[$];
    vec_t  tbl[10];
    int    checks = 0;
    int    failures = 0;
    logic  in_pld = 1'b0;
    logic [63:0] aad_sum = 64'd0;
    logic [63:0] pld_sum = 64'd0;

    localparam logic [127:0] D0  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] P1  = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
    localparam logic [127:0] P2  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] A16 = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;

    task automatic chk_pop(input logic [1:0] kind, input logic [127:0] data, input logic [15:0] keep);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL handshake_unexpected kind=%0d data=%h", kind, data);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.data != data || (kind != K_LEN && e.keep != keep)) begin
                failures++;
                $display("FAIL block kind=%0d/%0d data=%h expected=%h keep=%h expected=%h",
                         kind, e.kind, data, e.data, keep, e.keep);
            end
        end
    endtask

    // Monitor: stability while stalled, exclusivity, scoreboard at handshakes.
    initial begin
        logic st_a, st_p, st_l;
        logic [143:0] sv_a, sv_p;
        logic [127:0] sv_l;
        st_a = 1'b0; st_p = 1'b0; st_l = 1'b0;
        sv_a = '0; sv_p = '0; sv_l = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                st_a = 1'b0; st_p = 1'b0; st_l = 1'b0;
            end else begin
                if (st_a) begin
                    checks++;
                    if (!aad_valid || {aad_keep, aad_data} != sv_a) begin
                        failures++;
                        $display("FAIL aad_stable valid=%b data=%h expected=%h", aad_valid, aad_data, sv_a[127:0]);
                    end
                end
                if (st_p) begin
                    checks++;
                    if (!pld_valid || {pld_keep, pld_data} != sv_p) begin
                        failures++;
                        $display("FAIL pld_stable valid=%b data=%h expected=%h", pld_valid, pld_data, sv_p[127:0]);
                    end
                end
                if (st_l) begin
                    checks++;
                    if (!len_valid || len_block != sv_l) begin
                        failures++;
                        $display("FAIL len_stable valid=%b len=%h expected=%h", len_valid, len_block, sv_l);
                    end
                end
                if (aad_valid || pld_valid || len_valid) begin
                    checks++;
                    if ({1'b0, aad_valid} + {1'b0, pld_valid} + {1'b0, len_valid} > 2'd1) begin
                        failures++;
                        $display("FAIL exclusive valids=%b%b%b required at most one", aad_valid, pld_valid, len_valid);
                    end
                end
                if (aad_valid && aad_ready) chk_pop(K_AAD, aad_data, aad_keep);
                if (pld_valid && pld_ready) chk_pop(K_PLD, pld_data, pld_keep);
                if (len_valid && len_ready) chk_pop(K_LEN, len_block, 16'h0000);
                st_a = aad_valid && !aad_ready; sv_a = {aad_keep, aad_data};
                st_p = pld_valid && !pld_ready; sv_p = {pld_keep, pld_data};
                st_l = len_valid && !len_ready; sv_l = len_block;
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_pld = 1'b0;
        aad_sum = 64'd0;
        pld_sum = 64'd0;
    endtask

    task automatic send_beat(input logic aad, input logic [15:0] k, input logic [127:0] d,
                             input logic last, input logic [127:0] expd);
        logic got;
        logic [1:0] kind;
        got = 1'b0;
        in_is_aad = aad; in_keep = k; in_data = d; in_last = last; in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL in_ready_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        if (!aad) in_pld = 1'b1;
        kind = (aad && !in_pld) ? K_AAD : K_PLD;
        if (kind == K_AAD) aad_sum = aad_sum + 64'($countones(k));
        else pld_sum = pld_sum + 64'($countones(k));
        if (k != 16'h0000) sb.push_back('{kind, expd, k});
        if (last) sb.push_back('{K_LEN, {pld_sum, aad_sum}, 16'h0000});
    endtask

    task automatic wait_done(input logic exp_err);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout done=%b required 1", done);
        end
        checks++;
        if (err != exp_err) begin
            failures++;
            $display("FAIL err err=%b required %b", err, exp_err);
        end
        checks++;
        if (sb.size() != 0 || !busy) begin
            failures++;
            $display("FAIL drained pending=%0d busy=%b required 0 and 1", sb.size(), busy);
        end
        @(negedge clk);
        checks++;
        if (done || busy) begin
            failures++;
            $display("FAIL done_pulse done=%b busy=%b required 0 0", done, busy);
        end
        sb.delete();
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if ({in_ready, aad_valid, pld_valid, len_valid, busy, done, err} != 7'd0
            || aad_data != 128'd0 || aad_keep != 16'd0 || pld_data != 128'd0
            || pld_keep != 16'd0 || len_block != 128'd0) begin
            failures++;
            $display("FAIL %s flags=%b%b%b%b%b%b%b len=%h data=%h required all 0", name,
                     in_ready, aad_valid, pld_valid, len_valid, busy, done, err, len_block, aad_data);
        end
    endtask

    initial begin
        logic got;
        tbl[0] = '{1'b1, 1'b1, 16'hFFFF, D0,  1'b0, D0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 16'h001F, A16, 1'b1, 128'h0000000000000000000000AAAAAAAAAA, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'hFFFF, P1,  1'b0, P1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'hFFFF, P2,  1'b1, P2, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 16'h0000, D0,  1'b1, 128'd0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 16'h0F0F, D0,  1'b0, 128'h000000004455667700000000CCDDEEFF, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 16'hFFFF, P1,  1'b1, P1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 16'h00FF, D0,  1'b0, 128'h00000000000000008899AABBCCDDEEFF, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 16'hFFFF, P2,  1'b1, P2, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 16'h0001, D0,  1'b1, 128'h000000000000000000000000000000FF, 1'b0};

        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].st) do_start();
            send_beat(tbl[i].is_aad, tbl[i].keep, tbl[i].data, tbl[i].last, tbl[i].exp_data);
            if (tbl[i].last) wait_done(tbl[i].exp_err);
        end

        // Backpressure on the AAD port for ten cycles.
        do_start();
        aad_ready = 1'b0;
        send_beat(1'b1, 16'hFFFF, D0, 1'b0, D0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (!aad_valid || aad_data != D0 || in_ready) begin
                failures++;
                $display("FAIL backpressure valid=%b data=%h in_ready=%b required 1 %h 0",
                         aad_valid, aad_data, in_ready, D0);
            end
        end
        @(posedge clk); #1 aad_ready = 1'b1;
        send_beat(1'b0, 16'h0003, P1, 1'b1, 128'h0000000000000000000000000000BA98);
        wait_done(1'b0);

        // Reset while a payload block is stalled.
        do_start();
        pld_ready = 1'b0;
        send_beat(1'b0, 16'hFFFF, P1, 1'b0, P1);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pld_valid) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL pld_valid_before_reset pld_valid=%b required 1", pld_valid);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk_zero("reset_midway");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pld_ready = 1'b1;
        do_start();
        send_beat(1'b0, 16'h007F, P2, 1'b1, 128'h00000000000000000096A5B4C3D2E1F0);
        wait_done(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
